input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 155 +++++++++++++++
 tb/tb_input_conditioner.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Three-button debouncer producing level plus press/release strobes.
// Define INPUT_COND_REPEAT_EN to add auto-repeat on the Execute button.
module input_conditioner #(
    parameter int DEB_CYCLES    = 50000,
    parameter int REPEAT_CYCLES = 25000000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [2:0] Btn_n,
    output logic [2:0] Level,
    output logic [2:0] Press,
    output logic [2:0] Release
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } btn_state_t;

    logic [2:0] sync1;
    logic [2:0] s;

    btn_state_t    state_q [3];
    btn_state_t    state_d [3];
    logic [CW-1:0] cnt_q   [3];
    logic [CW-1:0] cnt_d   [3];

    logic [2:0] level_d;
    logic [2:0] accept;
    logic [2:0] drop;
    logic [2:0] rep_mask;

    // Released level is 1 on the raw active-low inputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1 <= '1;
            s     <= '1;
        end else begin
            sync1 <= Btn_n;
            s     <= sync1;
        end
    end

    always_comb begin
        level_d = '0;
        accept  = '0;
        drop    = '0;
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                RELEASED: begin
                    if (!s[i]) begin
                        state_d[i] = PRESS_PEND;
                        cnt_d[i]   = CW'(1);
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                PRESS_PEND: begin
                    if (s[i]) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DEB_LAST) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                PRESSED: begin
                    if (s[i]) begin
                        state_d[i] = RELEASE_PEND;
                        cnt_d[i]   = CW'(1);
                    end
                end
                RELEASE_PEND: begin
                    if (!s[i]) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DEB_LAST) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: ;
            endcase
            level_d[i] = (state_d[i] == PRESSED) ||
                         (state_d[i] == RELEASE_PEND);
            accept[i]  = (state_q[i] == PRESS_PEND) &&
                         (state_d[i] == PRESSED);
            drop[i]    = (state_q[i] == RELEASE_PEND) &&
                         (state_d[i] == RELEASED);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= RELEASED;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

`ifdef INPUT_COND_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt;
    logic          exec_held;
    logic          rep_fire;

    assign exec_held = (state_q[2] == PRESSED);
    assign rep_fire  = exec_held && (rep_cnt == REP_LAST);
    assign rep_mask  = {rep_fire, 2'b00};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rep_cnt <= '0;
        end else if (!exec_held || rep_fire) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end
`else
    assign rep_mask = '0;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Level   <= '0;
            Press   <= '0;
            Release <= '0;
        end else begin
            Level   <= level_d;
            Press   <= accept | rep_mask;
            Release <= drop;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner (DEB_CYCLES=4, REPEAT_CYCLES=8).
// Expected outputs are queued per cycle when stimulus is driven.
module tb_input_conditioner;

    localparam int DEB = 4;
    localparam int REP = 8;
    localparam int LAT = DEB + 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] btn_n = 3'b111;
    logic [2:0] level;
    logic [2:0] press;
    logic [2:0] rel;

    input_conditioner #(
        .DEB_CYCLES   (DEB),
        .REPEAT_CYCLES(REP)
    ) dut (
        .Clk    (clk),
        .Reset  (rst_n),
        .Btn_n  (btn_n),
        .Level  (level),
        .Press  (press),
        .Release(rel)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int         due;
        logic [2:0] l;
        logic [2:0] p;
        logic [2:0] r;
    } exp_t;

    exp_t  sb     [$];
    string sb_tag [$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(string tag, logic [2:0] got, logic [2:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %b want %b (cycle %0d)",
                     tag, got, want, cyc);
        end
    endtask

    task automatic expect_at(string tag, int due,
                             logic [2:0] l, logic [2:0] p, logic [2:0] r);
        sb.push_back('{due: due, l: l, p: p, r: r});
        sb_tag.push_back(tag);
    endtask

    task automatic expect_span(string tag, int from, int to,
                               logic [2:0] l, logic [2:0] p, logic [2:0] r);
        for (int c = from; c <= to; c++) expect_at(tag, c, l, p, r);
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t  e;
        string t;
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            t = sb_tag.pop_front();
            check($sformatf("%s.level@%0d", t, e.due), level, e.l);
            check($sformatf("%s.press@%0d", t, e.due), press, e.p);
            check($sformatf("%s.release@%0d", t, e.due), rel, e.r);
        end
    end

    initial begin
        int k;
        int r;
        int t;
        logic [2:0] el;
        logic [2:0] ep;
        logic [2:0] er;

        // reset with all buttons released
        expect_span("rst", 1, 3, 3'b000, 3'b000, 3'b000);
        step(3);
        rst_n = 1'b1;
        expect_span("idle", 4, 8, 3'b000, 3'b000, 3'b000);
        step(5);

        // LoadA press and release latency
        btn_n = 3'b110;
        k = cyc;
        expect_span("a_pend", k + 1, k + LAT - 1, 3'b000, 3'b000, 3'b000);
        expect_at("a_press", k + LAT, 3'b001, 3'b001, 3'b000);
        expect_span("a_held", k + LAT + 1, k + 12, 3'b001, 3'b000, 3'b000);
        step(12);
        btn_n = 3'b111;
        k = cyc;
        expect_span("a_rpend", k + 1, k + LAT - 1, 3'b001, 3'b000, 3'b000);
        expect_at("a_rel", k + LAT, 3'b000, 3'b000, 3'b001);
        expect_span("a_idle", k + LAT + 1, k + 10, 3'b000, 3'b000, 3'b000);
        step(10);

        // LoadB bouncing shorter than the debounce window
        btn_n = 3'b101;
        k = cyc;
        expect_span("b_glitch", k + 1, k + 20, 3'b000, 3'b000, 3'b000);
        step(3);
        btn_n = 3'b111;
        step(1);
        btn_n = 3'b101;
        step(3);
        btn_n = 3'b111;
        step(13);

        // release bounce while held must not drop the level
        btn_n = 3'b110;
        k = cyc;
        expect_span("rb_pend", k + 1, k + LAT - 1, 3'b000, 3'b000, 3'b000);
        expect_at("rb_press", k + LAT, 3'b001, 3'b001, 3'b000);
        expect_span("rb_held", k + LAT + 1, k + 25, 3'b001, 3'b000, 3'b000);
        expect_at("rb_rel", k + 26, 3'b000, 3'b000, 3'b001);
        expect_span("rb_idle", k + 27, k + 29, 3'b000, 3'b000, 3'b000);
        step(10);
        btn_n = 3'b111;
        step(3);
        btn_n = 3'b110;
        step(7);
        btn_n = 3'b111;
        step(9);

        // all three buttons on the same edge
        btn_n = 3'b000;
        k = cyc;
        expect_span("all_pend", k + 1, k + LAT - 1, 3'b000, 3'b000, 3'b000);
        expect_at("all_press", k + LAT, 3'b111, 3'b111, 3'b000);
        expect_span("all_held", k + LAT + 1, k + 10, 3'b111, 3'b000, 3'b000);
        step(10);
        btn_n = 3'b111;
        k = cyc;
        expect_span("all_rpend", k + 1, k + LAT - 1, 3'b111, 3'b000, 3'b000);
        expect_at("all_rel", k + LAT, 3'b000, 3'b000, 3'b111);
        expect_span("all_idle", k + LAT + 1, k + 10, 3'b000, 3'b000, 3'b000);
        step(10);

        // reset while Execute is held
        btn_n = 3'b011;
        k = cyc;
        expect_span("x_pend", k + 1, k + LAT - 1, 3'b000, 3'b000, 3'b000);
        expect_at("x_press", k + LAT, 3'b100, 3'b100, 3'b000);
        expect_span("x_held", k + LAT + 1, k + LAT + 2, 3'b100, 3'b000, 3'b000);
        step(LAT + 3);
        rst_n = 1'b0;
        #1;
        check("rst_async.level", level, 3'b000);
        check("rst_async.press", press, 3'b000);
        check("rst_async.release", rel, 3'b000);
        r = cyc;
        expect_span("x_rst", r, r + 7, 3'b000, 3'b000, 3'b000);
        expect_at("x_repress", r + 8, 3'b100, 3'b100, 3'b000);
        expect_span("x_held2", r + 9, r + 11, 3'b100, 3'b000, 3'b000);
        step(2);
        rst_n = 1'b1;
        step(9);
        btn_n = 3'b111;
        k = cyc;
        expect_span("x_rpend", k + 1, k + LAT - 1, 3'b100, 3'b000, 3'b000);
        expect_at("x_rel", k + LAT, 3'b000, 3'b000, 3'b100);
        expect_span("x_idle", k + LAT + 1, k + 9, 3'b000, 3'b000, 3'b000);
        step(9);

        // LoadA and Execute held 40 cycles: repeat only on Execute
        btn_n = 3'b010;
        k = cyc;
        for (int c = k + 1; c <= k + 40 + LAT + 4; c++) begin
            t  = c - k - LAT;
            el = (t >= 0 && c < k + 40 + LAT) ? 3'b101 : 3'b000;
            ep = (t == 0) ? 3'b101 : 3'b000;
            er = (c == k + 40 + LAT) ? 3'b101 : 3'b000;
`ifdef INPUT_COND_REPEAT_EN
            if (t > 0 && (t % REP) == 0 && c <= k + 42) ep = 3'b100;
`endif
            expect_at("hold40", c, el, ep, er);
        end
        step(40);
        btn_n = 3'b111;
        step(LAT + 4);

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        check("drain_empty", 3'(sb.size() != 0), 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
